// File: rtl/pwm_cfg_sequencer_if.sv
// pwm_cfg_sequencer_if: command port, status and APB write bus for the PWM reprogramming sequencer.
interface pwm_cfg_sequencer_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [31:0] cmd_pre;
    logic [31:0] cmd_cmp1;
    logic [31:0] cmd_cmp2;
    logic        cmd_en;
    logic        busy;
    logic        done;
    logic        err;
    logic        PSEL;
    logic        PENABLE;
    logic        PWRITE;
    logic [17:0] PADDR;
    logic [31:0] PWDATA;
    logic        PREADY;
    modport master (
        input  cmd_valid, cmd_pre, cmd_cmp1, cmd_cmp2, cmd_en, PREADY,
        output cmd_ready, busy, done, err, PSEL, PENABLE, PWRITE, PADDR, PWDATA
    );
    modport slave (
        output cmd_valid, cmd_pre, cmd_cmp1, cmd_cmp2, cmd_en, PREADY,
        input  cmd_ready, busy, done, err, PSEL, PENABLE, PWRITE, PADDR, PWDATA
    );
endinterface

// File: rtl/pwm_cfg_sequencer.sv
// pwm_cfg_sequencer: APB master that rewrites the PWM32 PRE/TMRCMP1/TMRCMP2/TMREN registers from one command.
module pwm_cfg_sequencer #(
    parameter int TIMEOUT       = 16,
    parameter bit DISABLE_FIRST = 1'b1
) (
    input logic                 PCLK,
    input logic                 PRESETn,
    pwm_cfg_sequencer_if.master bus
);
    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] SETUP  = 2'd1;
    localparam logic [1:0] ACCESS = 2'd2;
    localparam logic [1:0] DONE   = 2'd3;
    localparam int WW = $clog2(TIMEOUT + 1);
    localparam logic [WW-1:0] WAIT_MAX = WW'(TIMEOUT - 1);
    localparam logic [2:0] FIRST = DISABLE_FIRST ? 3'd0 : 3'd1;
    logic [1:0]    state_q, state_d;
    logic [2:0]    idx_q, idx_d;
    logic [WW-1:0] wait_q, wait_d;
    logic [31:0]   pre_q, pre_d, cmp1_q, cmp1_d, cmp2_q, cmp2_d;
    logic          en_q, en_d, err_q, err_d;
    logic          sel;
    logic [17:0]   addr;
    logic [31:0]   wdata;
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        wait_d  = wait_q;
        pre_d   = pre_q;
        cmp1_d  = cmp1_q;
        cmp2_d  = cmp2_q;
        en_d    = en_q;
        err_d   = err_q;
        if (state_q == IDLE && bus.cmd_valid) begin
            state_d = SETUP;
            idx_d   = FIRST;
            err_d   = 1'b0;
            pre_d   = bus.cmd_pre;
            cmp1_d  = bus.cmd_cmp1;
            cmp2_d  = bus.cmd_cmp2;
            en_d    = bus.cmd_en;
        end else if (state_q == SETUP) begin
            state_d = ACCESS;
            wait_d  = '0;
        end else if (state_q == ACCESS) begin
            if (bus.PREADY) begin
                state_d = (idx_q == 3'd4) ? DONE : SETUP;
                idx_d   = idx_q + 3'd1;
            end else if (wait_q == WAIT_MAX) begin
                // TIMEOUT-th stalled cycle: abandon the remaining writes
                state_d = DONE;
                err_d   = 1'b1;
            end else begin
                wait_d = wait_q + 1'b1;
            end
        end else if (state_q == DONE) begin
            state_d = IDLE;
        end
    end
    always_ff @(posedge PCLK) begin
        if (!PRESETn) begin
            state_q <= IDLE;
            idx_q   <= '0;
            wait_q  <= '0;
            pre_q   <= '0;
            cmp1_q  <= '0;
            cmp2_q  <= '0;
            en_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            wait_q  <= wait_d;
            pre_q   <= pre_d;
            cmp1_q  <= cmp1_d;
            cmp2_q  <= cmp2_d;
            en_q    <= en_d;
            err_q   <= err_d;
        end
    end
    assign sel   = (state_q == SETUP) || (state_q == ACCESS);
    assign addr  = (idx_q == 3'd1) ? 18'h4 : (idx_q == 3'd2) ? 18'h1 : (idx_q == 3'd3) ? 18'h2 : 18'h8;
    assign wdata = (idx_q == 3'd1) ? pre_q : (idx_q == 3'd2) ? cmp1_q : (idx_q == 3'd3) ? cmp2_q :
                   (idx_q == 3'd4) ? {31'b0, en_q} : 32'h0;
    assign bus.PSEL      = sel;
    assign bus.PENABLE   = (state_q == ACCESS);
    assign bus.PWRITE    = sel;
    assign bus.PADDR     = sel ? addr : '0;
    assign bus.PWDATA    = sel ? wdata : '0;
    assign bus.cmd_ready = (state_q == IDLE);
    assign bus.busy      = (state_q != IDLE);
    assign bus.done      = (state_q == DONE);
    assign bus.err       = err_q;
endmodule
